// File: rtl/mem_request_responder_pkg.sv
// Shared types for the memory request responder: FSM states, request kinds,
// default bus widths and the wait-counter sizing helper.
package mem_if_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    READ_WAIT,
    HOLD,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    REQ_FETCH,
    REQ_LOAD,
    REQ_STORE
  } reqKind_t;

  // One counter serves both the read latency and the wait states.
  // It only has to reach its limit minus one, so it never needs more than one bit per halving of that limit.
  function automatic int cntWidth(input int memLat, input int waitStates);
    int maxCount;
    maxCount = (memLat > waitStates) ? memLat : waitStates;
    return (maxCount < 2) ? 1 : $clog2(maxCount);
  endfunction

endpackage

// File: rtl/mem_request_responder_if.sv
// Control-unit and SRAM facing signals of the responder, bundled into one interface.
// The master side is the environment: the control unit, the datapath and the SRAM.
interface mem_request_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);

  logic              instRead;
  logic              dataMemRead;
  logic              memWrite;
  logic [ADDR_W-1:0] pcAddr;
  logic [ADDR_W-1:0] dataAddr;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] instOut;
  logic [DATA_W-1:0] dataOut;
  logic              memReady;
  logic              busy;
  logic              errConflict;
  logic              errOverrun;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output instRead, dataMemRead, memWrite, pcAddr, dataAddr, writeData, sram_rdata,
    input  instOut, dataOut, memReady, busy, errConflict, errOverrun,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  instRead, dataMemRead, memWrite, pcAddr, dataAddr, writeData, sram_rdata,
    output instOut, dataOut, memReady, busy, errConflict, errOverrun,
           sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/mem_request_responder_strobe_edge_detect.sv
// Registered rising-edge detector for the three request strobes.
// Because it samples every cycle, a strobe that is held high never fires a second time.
module strobe_edge_detect (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [2:0] strobe,
  output logic [2:0] rise
);

  logic [2:0] prevStrobe;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) prevStrobe <= '0;
    else          prevStrobe <= strobe;
  end

  assign rise = strobe & ~prevStrobe;

endmodule

// File: rtl/mem_request_responder.sv
// Turns control-unit strobes into single SRAM accesses.
// It returns fetched and loaded words in held registers and pulses memReady when an access completes.
module mem_request_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MEM_LAT     = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic Clock,
  input  logic Reset_n,
  mem_request_responder_if.slave bus
);

  localparam int CNT_W = cntWidth(MEM_LAT, WAIT_STATES);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            state, nextState;
  reqKind_t          kind, winKind;
  logic [2:0]        rise;
  logic              anyRise, multiRise, readDone;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addrLat;
  logic [DATA_W-1:0] wdataLat, instReg, dataReg;
  logic              errConflictReg, errOverrunReg;

  strobe_edge_detect edgeDetect (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .strobe  ({bus.memWrite, bus.dataMemRead, bus.instRead}),
    .rise    (rise)
  );

  assign anyRise   = |rise;
  assign multiRise = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
  assign readDone  = (state == READ_WAIT) && (cnt == LAT_LAST);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Stores outrank loads, and loads outrank fetches. A losing strobe is dropped.
  always_comb begin
    nextState = state;
    winKind   = REQ_FETCH;
    if (rise[2])      winKind = REQ_STORE;
    else if (rise[1]) winKind = REQ_LOAD;
    case (state)
      IDLE:      if (anyRise) nextState = ACCESS;
      ACCESS:    if (kind != REQ_STORE)     nextState = READ_WAIT;
                 else if (WAIT_STATES == 0) nextState = DONE;
                 else                       nextState = HOLD;
      READ_WAIT: if (readDone) nextState = (WAIT_STATES == 0) ? DONE : HOLD;
      HOLD:      if (cnt == WAIT_LAST) nextState = DONE;
      DONE:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      kind           <= REQ_FETCH;
      addrLat        <= '0;
      wdataLat       <= '0;
      cnt            <= '0;
      instReg        <= '0;
      dataReg        <= '0;
      errConflictReg <= 1'b0;
      errOverrunReg  <= 1'b0;
    end else begin
      errConflictReg <= multiRise;
      if (anyRise && state != IDLE) errOverrunReg <= 1'b1;
      if (state == IDLE && anyRise) begin
        kind     <= winKind;
        addrLat  <= (winKind == REQ_FETCH) ? bus.pcAddr : bus.dataAddr;
        wdataLat <= bus.writeData;
      end
      if (state != nextState)                      cnt <= '0;
      else if (state == READ_WAIT || state == HOLD) cnt <= cnt + CNT_W'(1);
      if (readDone) begin
        if (kind == REQ_FETCH) instReg <= bus.sram_rdata;
        else                   dataReg <= bus.sram_rdata;
      end
    end
  end

  assign bus.instOut     = instReg;
  assign bus.dataOut     = dataReg;
  assign bus.memReady    = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.errConflict = errConflictReg;
  assign bus.errOverrun  = errOverrunReg;
  assign bus.sram_en     = (state == ACCESS);
  assign bus.sram_we     = (state == ACCESS) && (kind == REQ_STORE);
  assign bus.sram_addr   = addrLat;
  assign bus.sram_wdata  = wdataLat;

endmodule

// File: tb/tb_mem_request_responder.sv
// Directed bench for mem_request_responder.
// One instance uses the default parameters and a second uses two wait states; each has its own SRAM model.
module tb_mem_request_responder;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   readyCount, enCount;

  mem_request_responder_if #(.DATA_W(16), .ADDR_W(10)) busA ();
  mem_request_responder_if #(.DATA_W(16), .ADDR_W(10)) busB ();

  mem_request_responder #(.DATA_W(16), .ADDR_W(10), .MEM_LAT(1), .WAIT_STATES(0)) dutA (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (busA)
  );

  mem_request_responder #(.DATA_W(16), .ADDR_W(10), .MEM_LAT(1), .WAIT_STATES(2)) dutB (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (busB)
  );

  always #5 Clock = ~Clock;

  // Single-port synchronous SRAMs with one cycle of read latency, preloaded on the first clock edge
  logic [15:0] memA [0:1023];
  logic [15:0] memB [0:1023];
  logic        memInit = 1'b0;

  always @(posedge Clock) begin
    if (!memInit) begin
      memA[10'h010] <= 16'hA5C3;
      memA[10'h020] <= 16'hBEEF;
      memInit       <= 1'b1;
    end else begin
      if (busA.sram_en) begin
        if (busA.sram_we) memA[busA.sram_addr] <= busA.sram_wdata;
        else              busA.sram_rdata <= memA[busA.sram_addr];
      end
      if (busB.sram_en) begin
        if (busB.sram_we) memB[busB.sram_addr] <= busB.sram_wdata;
        else              busB.sram_rdata <= memB[busB.sram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic iR, input logic dR, input logic mW,
                               input logic [9:0] pc, input logic [9:0] da, input logic [15:0] wd);
    busA.instRead    = iR;
    busA.dataMemRead = dR;
    busA.memWrite    = mW;
    busA.pcAddr      = pc;
    busA.dataAddr    = da;
    busA.writeData   = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 16'h0000);
    busB.instRead = 1'b0; busB.dataMemRead = 1'b0; busB.memWrite = 1'b0;
    busB.pcAddr = '0; busB.dataAddr = '0; busB.writeData = '0;
    tick(); tick();
    checkOutput("rst_memReady", {31'b0, busA.memReady}, 32'h0);
    checkOutput("rst_busy",     {31'b0, busA.busy},     32'h0);
    checkOutput("rst_sram_en",  {31'b0, busA.sram_en},  32'h0);
    checkOutput("rst_instOut",  {16'b0, busA.instOut},  32'h0);
    Reset_n = 1'b1;
    tick();

    // Test 1: a fetch with the default parameters
    $display("[TB] fetch with defaults");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h010, 10'h000, 16'h0000);
    tick();
    checkOutput("t1_sram_en",   {31'b0, busA.sram_en},   32'h1);
    checkOutput("t1_sram_we",   {31'b0, busA.sram_we},   32'h0);
    checkOutput("t1_sram_addr", {22'b0, busA.sram_addr}, 32'h010);
    checkOutput("t1_busy",      {31'b0, busA.busy},      32'h1);
    tick();
    checkOutput("t1_ready_T2",  {31'b0, busA.memReady},  32'h0);
    tick();
    checkOutput("t1_ready_T3",  {31'b0, busA.memReady},  32'h1);
    checkOutput("t1_instOut",   {16'b0, busA.instOut},   32'hA5C3);
    checkOutput("t1_dataOut",   {16'b0, busA.dataOut},   32'h0);
    tick();
    checkOutput("t1_ready_T4",  {31'b0, busA.memReady},  32'h0);
    checkOutput("t1_busy_T4",   {31'b0, busA.busy},      32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h010, 10'h000, 16'h0000);
    tick();

    // Test 2: a store followed by a load with two wait states
    $display("[TB] store then load, two wait states");
    busB.memWrite = 1'b1; busB.dataAddr = 10'h3FF; busB.writeData = 16'h1234;
    tick();
    checkOutput("t2_sram_we",    {31'b0, busB.sram_we},    32'h1);
    checkOutput("t2_sram_addr",  {22'b0, busB.sram_addr},  32'h3FF);
    checkOutput("t2_sram_wdata", {16'b0, busB.sram_wdata}, 32'h1234);
    tick();
    checkOutput("t2_ready_T2",   {31'b0, busB.memReady},   32'h0);
    tick();
    checkOutput("t2_ready_T3",   {31'b0, busB.memReady},   32'h0);
    tick();
    checkOutput("t2_ready_T4",   {31'b0, busB.memReady},   32'h1);
    checkOutput("t2_busy_T4",    {31'b0, busB.busy},       32'h1);
    tick();
    checkOutput("t2_busy_T5",    {31'b0, busB.busy},       32'h0);
    busB.memWrite = 1'b0;
    tick();
    busB.dataMemRead = 1'b1;
    tick(); tick(); tick(); tick();
    checkOutput("t2_ld_ready_T4", {31'b0, busB.memReady}, 32'h0);
    tick();
    checkOutput("t2_ld_ready_T5", {31'b0, busB.memReady}, 32'h1);
    checkOutput("t2_ld_dataOut",  {16'b0, busB.dataOut},  32'h1234);
    checkOutput("t2_ld_instOut",  {16'b0, busB.instOut},  32'h0);
    busB.dataMemRead = 1'b0;
    tick();

    // Test 3: simultaneous fetch and store edges, where the store wins
    $display("[TB] simultaneous fetch and store");
    applyStimulus(1'b1, 1'b0, 1'b1, 10'h020, 10'h055, 16'h7777);
    tick();
    checkOutput("t3_sram_we",     {31'b0, busA.sram_we},     32'h1);
    checkOutput("t3_sram_addr",   {22'b0, busA.sram_addr},   32'h055);
    checkOutput("t3_conflict_T1", {31'b0, busA.errConflict}, 32'h1);
    tick();
    checkOutput("t3_conflict_T2", {31'b0, busA.errConflict}, 32'h0);
    checkOutput("t3_ready_T2",    {31'b0, busA.memReady},    32'h1);
    tick();
    checkOutput("t3_instOut",     {16'b0, busA.instOut},     32'hA5C3);
    checkOutput("t3_mem_written", {16'b0, memA[10'h055]},    32'h7777);
    checkOutput("t3_sram_en_idle", {31'b0, busA.sram_en},    32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h020, 10'h055, 16'h0000);
    tick();

    // Test 4: a strobe held high for ten cycles produces exactly one access
    $display("[TB] held fetch strobe");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h010, 10'h000, 16'h0000);
    readyCount = 0;
    enCount    = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busA.memReady) readyCount++;
      if (busA.sram_en)  enCount++;
    end
    checkOutput("t4_ready_count", readyCount, 32'd1);
    checkOutput("t4_en_count",    enCount,    32'd1);
    checkOutput("t4_overrun",     {31'b0, busA.errOverrun}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h010, 10'h000, 16'h0000);
    tick();

    // Test 5: a load edge while busy is ignored and sets the sticky overrun flag
    $display("[TB] load edge while busy");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h010, 10'h055, 16'h0000);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h010, 10'h055, 16'h0000);
    tick();
    checkOutput("t5_overrun_T2", {31'b0, busA.errOverrun}, 32'h1);
    tick();
    checkOutput("t5_ready_T3",   {31'b0, busA.memReady},   32'h1);
    checkOutput("t5_dataOut_T3", {16'b0, busA.dataOut},    32'h0);
    tick();
    checkOutput("t5_overrun_T4", {31'b0, busA.errOverrun}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h010, 10'h055, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h010, 10'h055, 16'h0000);
    tick(); tick(); tick();
    checkOutput("t5_next_ready",   {31'b0, busA.memReady},   32'h1);
    checkOutput("t5_next_dataOut", {16'b0, busA.dataOut},    32'h7777);
    checkOutput("t5_overrun_held", {31'b0, busA.errOverrun}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h010, 10'h055, 16'h0000);
    tick();

    // Test 6: reset asserted during READ_WAIT aborts the fetch with no output update
    $display("[TB] reset during read wait");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h020, 10'h000, 16'h0000);
    tick(); tick();
    Reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_ready",   {31'b0, busA.memReady},   32'h0);
    checkOutput("t6_rst_busy",    {31'b0, busA.busy},       32'h0);
    checkOutput("t6_rst_instOut", {16'b0, busA.instOut},    32'h0);
    checkOutput("t6_rst_dataOut", {16'b0, busA.dataOut},    32'h0);
    checkOutput("t6_rst_overrun", {31'b0, busA.errOverrun}, 32'h0);
    tick();
    checkOutput("t6_rst_held_ready", {31'b0, busA.memReady}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h020, 10'h000, 16'h0000);
    Reset_n = 1'b1;
    tick();
    checkOutput("t6_idle_busy",  {31'b0, busA.busy},     32'h0);
    checkOutput("t6_idle_ready", {31'b0, busA.memReady}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h020, 10'h000, 16'h0000);
    tick(); tick(); tick();
    checkOutput("t6_refetch_ready",   {31'b0, busA.memReady}, 32'h1);
    checkOutput("t6_refetch_instOut", {16'b0, busA.instOut},  32'hBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h020, 10'h000, 16'h0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
